// File: rtl/pchri03_uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed start/data(LSB first)/[even parity]/stop.
// Each bit lasts CLKS_PER_BIT enabled cycles; tx_ready only in IDLE, so a held byte waits for the frame to end.
module pchri03_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_tx;
    logic          r_busy;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign tx_ready  = (r_state == S_IDLE) && ena;
    assign tx        = r_tx;
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else if (ena) begin
            if (r_state == S_IDLE) begin
                // The start bit goes out on the accepting edge itself.
                if (tx_ready && tx_valid) begin
                    r_shift  <= tx_data;
                    r_parity <= ^tx_data;
                    r_tx     <= 1'b0;
                    r_busy   <= 1'b1;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    r_state  <= S_START;
                end
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_idx == 3'd7) begin
                            r_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        r_tx    <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // r_idx counts stop bits here.
                        if (r_idx == LAST_STOP) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
